mux_stream_arb: RTL
===================

// Module: mux_stream_arb
// PURPOSE
//  Parametrised successor to the 4:1 select mux. Merges CH input streams of width N onto one
//  registered output stream with valid/ready handshakes, so that several producers can share
//  one consumer without dropping data.
//  Arbitration is selectable: manual select, fixed priority or round-robin.
//  It sits between producer blocks (e.g. display/UART data sources) and a single consumer.
// PARAMETERS
//  N     1   data width per channel (bits)
//  CH    4   number of input channels, 2..16
//  MODE  2   0 = manual (sel chooses), 1 = fixed priority (ch0 highest), 2 = round-robin
//  SW    $clog2(CH) (min 1)   width of sel/out_ch; localparam, not overridable
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous reset, active-low (rst==0 resets)
//  in_data    in   CH*N   flattened inputs; channel k occupies [k*N +: N]
//  in_valid   in   CH     per-channel valid
//  in_ready   out  CH     per-channel ready; at most one bit set per cycle
//  sel        in   SW     channel select, used only when MODE==0
//  out_data   out  N      registered output data
//  out_ch     out  SW     index of the channel that supplied out_data
//  out_valid  out  1      output register holds a beat
//  out_ready  in   1      consumer accepts the beat
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): out_valid=0, out_data=0, out_ch=0, RR pointer=0.
//    in_ready is forced to 0 while rst==0.
//  - Transfer on a side occurs when valid & ready are both 1 at a rising edge.
//  - Output register: one entry. load_en = !out_valid | out_ready.
//    in_ready[g] = load_en & grant[g] & rst. in_ready is combinational from in_valid, sel,
//    out_valid, out_ready and the pointer. It does not depend on in_data.
//  - Accept of channel g: the next edge sets out_data=in_data[g], out_ch=g, out_valid=1.
//    Latency from input accept to out_valid = 1 cycle.
//    Throughput = 1 beat/cycle when out_ready is held at 1.
//  - Output drained with no accept: out_valid -> 0. out_data and out_ch keep their last values.
//  - Stall (out_valid & !out_ready): out_data, out_ch and out_valid must not change.
//    All in_ready=0.
//  - Grant, MODE 0: grant=onehot(sel) if sel<CH and in_valid[sel]; otherwise no grant.
//    Other channels are never ready. A sel change takes effect the same cycle.
//  - Grant, MODE 1: lowest-index valid channel wins.
//  - Grant, MODE 2: first valid channel searching ptr, ptr+1, ..., wrapping CH-1 -> 0.
//    After an accepted transfer from g, ptr <= (g==CH-1) ? 0 : g+1.
//    With no accept, ptr holds.
//    Fairness: a continuously valid channel is served within CH accepts.
//  - No valid inputs: no grant, all in_ready=0, ptr holds.
//  - Simultaneous drain and accept in one cycle: the new beat replaces the old; out_valid stays 1.
//  - Reset mid-stream: a held beat is discarded; the pointer returns to 0.
//  - sel >= CH (CH not a power of 2): treated as no grant.
// STRUCTURE
//  - Shared header mux_defs.vh holds localparams MUX_MODE_SEL=0, MUX_MODE_FIXED=1,
//    MUX_MODE_RR=2, and a CLOG2 helper macro/function for SW.
//  - One sub-module, rr_arbiter #(CH, MODE):
//    inputs req[CH], sel, advance, clk, rst.
//    Outputs grant[CH] one-hot and grant_idx[SW].
//    It owns the RR pointer.
//  - The top level holds the output register, the handshake and the data slice/mux.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with all in_valid=1 -> in_ready=0, out_valid=0,
//     out_data=0. After release, the first accept is ch0 and out_valid=1 one cycle later.
//  2. RR fairness (N=8, CH=4, MODE=2, out_ready=1): all valid, data=8'hA0+k ->
//     out_ch sequence 0,1,2,3,0 and out_data A0,A1,A2,A3,A0 on consecutive cycles.
//  3. Backpressure: out_ready=0 for 4 cycles with a beat held -> out_data/out_ch stable,
//     all in_ready=0, ptr unchanged. On out_ready=1, a new beat loads in the same cycle
//     (no bubble).
//  4. Sparse RR: only ch1 and ch3 valid, ptr=2 -> grant ch3, then ch1, then ch3.
//     An idle cycle with no valid inputs leaves ptr unchanged.
//  5. MODE=1: ch2 and ch3 valid continuously -> ch2 always wins; ch3 starves;
//     in_ready[3]=0 throughout.
//  6. MODE=0, CH=3: sel=1 with in_valid=3'b101 -> no grant.
//     sel=2 -> ch2 accepted, out_ch=2. sel=3 -> no grant, no X on outputs.

Source files
------------

// File: rtl/mux_stream_arb_pkg.sv
// Shared mode encodings and select-width helper for the stream arbiter mux.
package mux_stream_arb_pkg;

    localparam int unsigned MuxModeSel   = 0;
    localparam int unsigned MuxModeFixed = 1;
    localparam int unsigned MuxModeRr    = 2;

    // Width of a channel index; never below one bit so CH==2 still gets a port.
    function automatic int unsigned sel_width(input int unsigned ch);
        return (ch <= 2) ? 1 : $clog2(ch);
    endfunction

endpackage

// File: rtl/mux_stream_arb_rr_arbiter.sv
// Grant generation (manual / fixed priority / round-robin); owns the round-robin pointer.
module mux_stream_arb_rr_arbiter
    import mux_stream_arb_pkg::*;
#(
    parameter int unsigned CH   = 4,
    parameter int unsigned MODE = MuxModeRr,
    localparam int unsigned SW  = sel_width(CH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [CH-1:0] req_i,
    input  logic [SW-1:0] sel_i,
    input  logic          advance_i,
    output logic [CH-1:0] grant_o,
    output logic [SW-1:0] grant_idx_o
);

    logic [SW-1:0] ptr_q, ptr_d;

    always_comb begin
        logic found;
        found       = 1'b0;
        grant_o     = '0;
        grant_idx_o = '0;
        if (MODE == MuxModeSel) begin
            // Out-of-range selects match no channel and so grant nothing.
            for (int k = 0; k < int'(CH); k++) begin
                if (sel_i == SW'(k) && req_i[k]) begin
                    grant_o[k]  = 1'b1;
                    grant_idx_o = SW'(k);
                end
            end
        end else if (MODE == MuxModeFixed) begin
            for (int k = 0; k < int'(CH); k++) begin
                if (!found && req_i[k]) begin
                    found       = 1'b1;
                    grant_o[k]  = 1'b1;
                    grant_idx_o = SW'(k);
                end
            end
        end else begin
            // Two passes: channels at/after the pointer first, then the wrapped ones.
            for (int k = 0; k < int'(CH); k++) begin
                if (!found && req_i[k] && k >= int'(ptr_q)) begin
                    found       = 1'b1;
                    grant_o[k]  = 1'b1;
                    grant_idx_o = SW'(k);
                end
            end
            for (int k = 0; k < int'(CH); k++) begin
                if (!found && req_i[k] && k < int'(ptr_q)) begin
                    found       = 1'b1;
                    grant_o[k]  = 1'b1;
                    grant_idx_o = SW'(k);
                end
            end
        end
    end

    always_comb begin
        ptr_d = (grant_idx_o == SW'(CH - 1)) ? '0 : grant_idx_o + SW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mux_stream_arb.sv
// CH-input valid/ready stream merger with a single registered output beat.
module mux_stream_arb
    import mux_stream_arb_pkg::*;
#(
    parameter int unsigned N    = 1,
    parameter int unsigned CH   = 4,
    parameter int unsigned MODE = MuxModeRr,
    localparam int unsigned SW  = sel_width(CH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [CH*N-1:0] in_data_i,
    input  logic [CH-1:0]   in_valid_i,
    output logic [CH-1:0]   in_ready_o,
    input  logic [SW-1:0]   sel_i,
    output logic [N-1:0]    out_data_o,
    output logic [SW-1:0]   out_ch_o,
    output logic            out_valid_o,
    input  logic            out_ready_i
);

    logic [CH-1:0] grant;
    logic [SW-1:0] grant_idx;
    logic          load_en;
    logic          accept;
    logic [N-1:0]  mux_data;
    logic [N-1:0]  out_data_q;
    logic [SW-1:0] out_ch_q;
    logic          out_valid_q;

    mux_stream_arb_rr_arbiter #(
        .CH   (CH),
        .MODE (MODE)
    ) u_arbiter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (in_valid_i),
        .sel_i       (sel_i),
        .advance_i   (accept),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign load_en    = !out_valid_q || out_ready_i;
    assign in_ready_o = grant & {CH{load_en & rst_ni}};
    // A grant is only ever issued to a valid channel, so any ready bit is a transfer.
    assign accept     = |in_ready_o;

    always_comb begin
        mux_data = '0;
        for (int k = 0; k < int'(CH); k++) begin
            if (grant[k]) begin
                mux_data = in_data_i[k*N +: N];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mux_data;
            out_ch_q    <= grant_idx;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;

endmodule
